dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arb_grant.sv | 25 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester ids.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    // One-hot grant bit positions.
    localparam int GNT_CPU = 0;
    localparam int GNT_DMA = 1;

    // Map a one-hot grant vector to the requester id it selects.
    function automatic req_id_e gnt_to_id(input logic [1:0] gnt);
        return gnt[GNT_DMA] ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant selection for two requesters. On contention the requester that was
// not granted last wins; last_dma_i=1 therefore favours the CPU.
module dmem_arb_grant
    import dmem_arbiter_pkg::*;
(
    input  logic       cpu_req_i,
    input  logic       dma_req_i,
    input  logic       last_dma_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; zero when nobody requests.
    always_comb begin
        gnt_o = 2'b00;
        if (cpu_req_i && dma_req_i) begin
            if (last_dma_i) gnt_o[GNT_CPU] = 1'b1;
            else            gnt_o[GNT_DMA] = 1'b1;
        end else if (cpu_req_i) begin
            gnt_o[GNT_CPU] = 1'b1;
        end else if (dma_req_i) begin
            gnt_o[GNT_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data memory between the CPU memory
// stage and a DMA engine. One access in flight at a time:
// IDLE -> ISSUE (mem_en pulse) -> WAIT (latency count) -> DONE (ack).
// Optional macro DMEM_ARB_RR_EN: round-robin on contention; without it the
// CPU always wins and no pointer register is built.
module dmem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    import dmem_arbiter_pkg::*;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    arb_state_e            state_q;
    logic [3:0]            cnt_q;
    req_id_e               owner_q;
    logic                  we_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  cpu_ack_q;
    logic                  dma_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dma_rdata_q;
    logic [1:0]            gnt;
    logic                  last_dma;
    logic                  enter_done;

`ifdef DMEM_ARB_RR_EN
    logic last_dma_q;
    logic last_dma_d;

    // Pointer follows every grant; reset points at DMA so the CPU wins first.
    always_comb begin
        last_dma_d = last_dma_q;
        if (state_q == ST_IDLE && gnt != 2'b00) last_dma_d = gnt[GNT_DMA];
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) last_dma_q <= 1'b1;
        else          last_dma_q <= last_dma_d;
    end

    assign last_dma = last_dma_q;
`else
    // Fixed priority: pretend DMA always won last, so the CPU wins ties.
    assign last_dma = 1'b1;
`endif

    dmem_arb_grant u_grant (
        .cpu_req_i  (cpu_req),
        .dma_req_i  (dma_req),
        .last_dma_i (last_dma),
        .gnt_o      (gnt)
    );

    // Edge on which DONE is entered: ack is raised and load data captured.
    always_comb begin
        enter_done = 1'b0;
        if (state_q == ST_ISSUE && MEM_LATENCY == 1) enter_done = 1'b1;
        if (state_q == ST_WAIT && cnt_q == 4'd1)     enter_done = 1'b1;
    end

    // Arbiter FSM with registered memory strobes, acks and read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner_q  <= gnt_to_id(gnt);
                        mem_en_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                        if (gnt[GNT_DMA]) begin
                            we_q        <= dma_we;
                            mem_we_q    <= dma_we;
                            mem_addr_q  <= dma_addr;
                            mem_wdata_q <= dma_wdata;
                        end else begin
                            we_q        <= cpu_we;
                            mem_we_q    <= cpu_we;
                            mem_addr_q  <= cpu_addr;
                            mem_wdata_q <= cpu_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= LAT_LOAD;
                    state_q  <= (MEM_LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    // Address and write data stay on the bus until DONE.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (enter_done) begin
                if (owner_q == REQ_CPU) begin
                    cpu_ack_q <= 1'b1;
                    if (!we_q) cpu_rdata_q <= mem_rdata;
                end else begin
                    dma_ack_q <= 1'b1;
                    if (!we_q) dma_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios on a MEM_LATENCY=2 instance,
// a MEM_LATENCY=1 instance, and a randomized run against a transaction model.
module tb_dmem_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, dma_ack, cpu_stall, mem_en, mem_we;

    logic          cpu_req1, cpu_we1, cpu_ack1, cpu_stall1, dma_ack1, mem_en1, mem_we1;
    logic [AW-1:0] cpu_addr1, mem_addr1;
    logic [DW-1:0] cpu_wdata1, cpu_rdata1, dma_rdata1, mem_wdata1, mem_rdata1;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_wdata('0),
        .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    function automatic logic [31:0] mem_init(input int i);
        return (i == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i) * 32'h0101;
    endfunction

    // Memory for the latency-2 instance: data is only valid on the cycle the
    // arbiter must capture it, garbage elsewhere.
    logic [31:0] mem_arr [0:63];
    int          ph;
    always @(posedge clk) begin
        if (!reset_n) begin
            ph <= 0;
            for (int i = 0; i < 64; i++) mem_arr[i] <= mem_init(i);
        end else begin
            if (mem_en)                ph <= 1;
            else if (ph != 0 && ph < 32) ph <= ph + 1;
            if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata  = (!mem_en && ph == LAT - 1) ? mem_arr[mem_addr[7:2]] : 32'hBAD0BAD0;
    // Latency-1 memory answers combinationally while mem_en is high.
    assign mem_rdata1 = mem_en1 ? ~mem_addr1 : 32'hBAD0BAD0;

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        cpu_req1 = 0; cpu_we1 = 0; cpu_addr1 = '0; cpu_wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_ack, dma_ack, mem_en, mem_we, cpu_stall, cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b/%b en=%b we=%b stall=%b crd=%h drd=%h addr=%h wd=%h, want all 0",
                     cpu_ack, dma_ack, mem_en, mem_we, cpu_stall, cpu_rdata, dma_rdata, mem_addr, mem_wdata);
        end
        checks++;
        if ({cpu_ack1, dma_ack1, mem_en1, mem_we1, cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1: got nonzero outputs crd=%h addr=%h", cpu_rdata1, mem_addr1);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_en, cpu_ack, dma_ack} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got en/ack=%b%b%b want 000", mem_en, cpu_ack, dma_ack);
        end
    endtask

    task automatic test_cpu_load();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 32'h5555AAAA;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall_N: got %b want 1", cpu_stall); end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, cpu_ack} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL load_issue: got en=%b we=%b addr=%h ack=%b want 1 0 00000010 0", mem_en, mem_we, mem_addr, cpu_ack);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, cpu_ack, cpu_stall, mem_addr} !== {1'b0, 1'b0, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL load_wait: got en=%b ack=%b stall=%b addr=%h want 0 0 1 00000010", mem_en, cpu_ack, cpu_stall, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack, dma_ack, cpu_stall, cpu_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_done: got ack=%b dack=%b stall=%b rdata=%h want 1 0 0 deadbeef", cpu_ack, dma_ack, cpu_stall, cpu_rdata);
        end
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_after: got ack=%b rdata=%h want 0 deadbeef", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_dma_store();
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h12345678}) begin
            errors++;
            $display("FAIL store_issue: got en=%b we=%b addr=%h wd=%h want 1 1 00000020 12345678", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL store_we_pulse: got en/we=%b%b want 00", mem_en, mem_we); end
        @(negedge clk);
        checks++;
        if ({dma_ack, cpu_ack, dma_rdata, cpu_rdata} !== {1'b1, 1'b0, 32'h0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL store_done: got dack=%b cack=%b drd=%h crd=%h want 1 0 0 deadbeef", dma_ack, cpu_ack, dma_rdata, cpu_rdata);
        end
        dma_req = 0;
        @(negedge clk);
        checks++;
        if ({dma_ack, mem_arr[8]} !== {1'b0, 32'h12345678}) begin
            errors++;
            $display("FAIL store_mem: got dack=%b mem=%h want 0 12345678", dma_ack, mem_arr[8]);
        end
    endtask

    // Both requesters contend; grant order depends on the arbitration policy.
    task automatic test_arbitration();
        logic [31:0] exp_c, exp_d;
        int          own, exp_own;
        bit          ok;
        exp_c = 32'hDEADBEEF; exp_d = 32'h0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_own = i % 2;
`else
            exp_own = (i < 3) ? 0 : 1;
`endif
            ok = 0;
            for (int k = 0; k < 8 && !ok; k++) begin
                @(negedge clk);
                ok = (mem_en === 1'b1);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL arb_timeout%0d: no mem_en within 8 cycles", i);
                continue;
            end
            own = (mem_addr === 32'h80) ? 1 : 0;
            checks++;
            if (own != exp_own) begin errors++; $display("FAIL arb_owner%0d: got %0d want %0d", i, own, exp_own); end
            repeat (LAT) @(negedge clk);
            if (exp_own == 1) exp_d = mem_init(32); else exp_c = mem_init(16);
            checks++;
            if ({dma_ack, cpu_ack, cpu_rdata, dma_rdata} !== {exp_own == 1, exp_own == 0, exp_c, exp_d}) begin
                errors++;
                $display("FAIL arb_ack%0d: got dack=%b cack=%b crd=%h drd=%h want %b %b %h %h",
                         i, dma_ack, cpu_ack, cpu_rdata, dma_rdata, exp_own == 1, exp_own == 0, exp_c, exp_d);
            end
            if (exp_own == 1) dma_req = 0; else cpu_req = 0;
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            if (exp_own == 1) dma_req = 1; else cpu_req = 1;
`else
            if (i < 2) cpu_req = 1;
`endif
        end
        cpu_req = 0; dma_req = 0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rmid_issue: got en=%b want 1", mem_en); end
        @(negedge clk);
        reset_n = 0; cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_ack, dma_ack, mem_en, mem_we, cpu_stall, cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: got ack=%b/%b en=%b crd=%h drd=%h addr=%h want all 0",
                     cpu_ack, dma_ack, mem_en, cpu_rdata, dma_rdata, mem_addr);
        end
        reset_n = 1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({cpu_ack, dma_ack, mem_en} !== 3'b000) begin
                errors++;
                $display("FAIL rmid_no_ack: got cack=%b dack=%b en=%b want 000", cpu_ack, dma_ack, mem_en);
            end
        end
        cpu_req = 1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rmid_fresh_issue: got en=%b want 1", mem_en); end
        repeat (LAT) @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rmid_fresh_done: got ack=%b rdata=%h want 1 deadbeef", cpu_ack, cpu_rdata);
        end
        cpu_req = 0;
        @(negedge clk);
    endtask

    task automatic test_lat1();
        cpu_req1 = 1; cpu_we1 = 0; cpu_addr1 = 32'h44; cpu_wdata1 = 32'h0;
        @(negedge clk);
        checks++;
        if ({mem_en1, cpu_ack1} !== 2'b10) begin errors++; $display("FAIL lat1_issue: got en=%b ack=%b want 1 0", mem_en1, cpu_ack1); end
        @(negedge clk);
        checks++;
        if ({mem_en1, cpu_ack1, cpu_rdata1} !== {1'b0, 1'b1, ~32'h44}) begin
            errors++;
            $display("FAIL lat1_load_done: got en=%b ack=%b rdata=%h want 0 1 %h", mem_en1, cpu_ack1, cpu_rdata1, ~32'h44);
        end
        cpu_req1 = 0;
        @(negedge clk);
        cpu_req1 = 1; cpu_we1 = 1; cpu_addr1 = 32'h48; cpu_wdata1 = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if ({mem_en1, mem_we1, mem_wdata1} !== {1'b1, 1'b1, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL lat1_store_issue: got en=%b we=%b wd=%h want 1 1 a5a5a5a5", mem_en1, mem_we1, mem_wdata1);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack1, cpu_rdata1} !== {1'b1, ~32'h44}) begin
            errors++;
            $display("FAIL lat1_store_done: got ack=%b rdata=%h want 1 %h", cpu_ack1, cpu_rdata1, ~32'h44);
        end
        cpu_req1 = 0;
        @(negedge clk);
        checks++;
        if (cpu_ack1 !== 1'b0) begin errors++; $display("FAIL lat1_ack_pulse: got %b want 0", cpu_ack1); end
    endtask

    // Random traffic checked against a transaction model: serialized
    // accesses, each occupying LAT+2 edges, winner chosen by policy.
    task automatic test_random();
        logic [31:0] ref_mem [0:63];
        logic [31:0] exp_c, exp_d, t_addr, t_wdata, t_data;
        logic        t_we, e_en, e_ack, e_cack, e_dack;
        int          own, g, next_free;
        bit          act, last_dma;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_init(i);
        reset_n = 0; cpu_req = 0; dma_req = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        exp_c = '0; exp_d = '0; last_dma = 1; act = 0; next_free = 0; g = -100; own = 0;
        t_addr = '0; t_wdata = '0; t_data = '0; t_we = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            if (!act && cyc >= next_free && (cpu_req || dma_req)) begin
`ifdef DMEM_ARB_RR_EN
                if (cpu_req && dma_req) own = last_dma ? 0 : 1;
`else
                if (cpu_req && dma_req) own = 0;
`endif
                else own = dma_req ? 1 : 0;
                last_dma = (own == 1);
                t_we    = own ? dma_we : cpu_we;
                t_addr  = own ? dma_addr : cpu_addr;
                t_wdata = own ? dma_wdata : cpu_wdata;
                if (t_we) ref_mem[t_addr[7:2]] = t_wdata;
                else      t_data = ref_mem[t_addr[7:2]];
                g = cyc; next_free = cyc + LAT + 2; act = 1;
            end
            @(negedge clk);
            e_en   = act && (cyc == g);
            e_ack  = act && (cyc == g + LAT);
            e_cack = e_ack && own == 0;
            e_dack = e_ack && own == 1;
            checks++;
            if (mem_en !== e_en) begin errors++; $display("FAIL rnd_en@%0d: got %b want %b", cyc, mem_en, e_en); end
            if (e_en) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_wdata}) begin
                    errors++;
                    $display("FAIL rnd_bus@%0d: got we=%b addr=%h wd=%h want %b %h %h", cyc, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata);
                end
            end
            checks++;
            if ({cpu_ack, dma_ack} !== {e_cack, e_dack}) begin
                errors++;
                $display("FAIL rnd_ack@%0d: got c=%b d=%b want %b %b", cyc, cpu_ack, dma_ack, e_cack, e_dack);
            end
            if (e_ack && !t_we) begin
                if (own == 1) exp_d = t_data; else exp_c = t_data;
            end
            checks++;
            if ({cpu_rdata, dma_rdata} !== {exp_c, exp_d}) begin
                errors++;
                $display("FAIL rnd_rdata@%0d: got c=%h d=%h want %h %h", cyc, cpu_rdata, dma_rdata, exp_c, exp_d);
            end
            checks++;
            if (cpu_stall !== (cpu_req && !e_cack)) begin
                errors++;
                $display("FAIL rnd_stall@%0d: got %b want %b", cyc, cpu_stall, cpu_req && !e_cack);
            end
            if (e_ack) begin
                act = 0;
                if (own == 1) dma_req = 0; else cpu_req = 0;
            end else begin
                if (!cpu_req && $urandom_range(0, 3) == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 32'($urandom_range(0, 15)) << 2; cpu_wdata = $urandom;
                end
                if (!dma_req && $urandom_range(0, 3) == 0) begin
                    dma_req = 1; dma_we = 1'($urandom_range(0, 1));
                    dma_addr = 32'($urandom_range(0, 15)) << 2; dma_wdata = $urandom;
                end
            end
        end
        cpu_req = 0; dma_req = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_dma_store();
        test_arbitration();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
